// File: rtl/row_acc_pkg.sv
// Shared definitions for the row accumulator: FSM state encoding, default
// widths, and constant helpers for the signed range limits of a given width.
package row_acc_pkg;

  localparam int ELEMENT_WIDTH_DEF = 64;
  localparam int COUNT_WIDTH_DEF   = 8;

  // Widest element the range helpers support; callers truncate to their width.
  localparam int MAX_WIDTH = 128;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Most positive two's complement value of 'width' bits (zero-extended).
  function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
    max_pos = (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative two's complement value of 'width' bits (as a width-bit pattern).
  function automatic logic [MAX_WIDTH-1:0] max_neg(input int width);
    max_neg = MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/row_accumulator_if.sv
// Element-in / result-out bundle of the row accumulator.
//
// Handshake: both ports use strict valid/ready. A beat transfers on a rising
// clk edge where valid and ready are both 1. The source holds valid and its
// payload stable until the transfer; valid never waits on ready. Ready may
// depend combinationally on the opposite port (in_ready follows out_ready
// while a result is held), but never on in_valid.
interface row_accumulator_if #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int COUNT_WIDTH   = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [ELEMENT_WIDTH-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [ELEMENT_WIDTH-1:0] out_sum;
  logic [COUNT_WIDTH-1:0]   out_count;
  logic                     out_ovf;

  // Upstream element source plus downstream result sink, seen from outside.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/acc_adder.sv
// Combinational signed adder with overflow flag.
// Build option ROW_ACC_SATURATE_EN: when defined, an overflowing add clamps to
// the most positive / most negative value; otherwise the add wraps.
module acc_adder
  import row_acc_pkg::*;
#(
  parameter int WIDTH = ELEMENT_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] raw;

  // Overflow when both operands share a sign and the result sign differs.
  always_comb begin
    raw = a + b;
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  end

`ifdef ROW_ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(max_neg(WIDTH));

  // Clamp toward the operands' sign on overflow.
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  // Plain modulo-2^WIDTH result.
  always_comb begin
    sum = raw;
  end
`endif

endmodule

// File: rtl/row_accumulator.sv
// Row accumulator: sums a stream of signed elements into one result per row
// (a row ends at the element flagged in_last) and presents sum, element count
// and overflow flag on a valid/ready result port.
// Build option ROW_ACC_SATURATE_EN selects saturating adds (see acc_adder).
module row_accumulator
  import row_acc_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  row_accumulator_if.slave   bus,
  output state_e             dbg_state
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]               state;
  logic [ELEMENT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0]   cnt;
  logic                     ovf;

  logic                     accept;
  logic [ELEMENT_WIDTH-1:0] add_a;
  logic [ELEMENT_WIDTH-1:0] add_sum;
  logic                     add_ovf;
  logic [COUNT_WIDTH-1:0]   cnt_base;
  logic [COUNT_WIDTH-1:0]   cnt_next;
  logic                     row_ovf;

  // While a result is held, a new element may only enter as that result drains.
  assign bus.in_ready = (state == S_ACCUM) | ((state == S_HOLD) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign dbg_state    = state_e'(state);

  // Running-row operands. In HOLD the accepted element starts a fresh row, so
  // the single adder is seeded with zero instead of the (already cleared) acc.
  always_comb begin
    add_a    = (state == S_ACCUM) ? acc : '0;
    cnt_base = (state == S_ACCUM) ? cnt : '0;
    row_ovf  = ((state == S_ACCUM) & ovf) | add_ovf;
    // Counter sticks at all-ones; the sum keeps accumulating regardless.
    cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + COUNT_WIDTH'(1);
  end

  acc_adder #(
    .WIDTH (ELEMENT_WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (bus.in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Row accumulation, result capture and HOLD/ACCUM sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_ACCUM;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (accept && bus.in_last) begin
      // Row closes: publish the result and clear the running row.
      bus.out_sum   <= add_sum;
      bus.out_count <= cnt_next;
      bus.out_ovf   <= row_ovf;
      bus.out_valid <= 1'b1;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      state         <= S_HOLD;
    end else if (accept) begin
      // Mid-row element; from HOLD this also means the old result drained.
      acc           <= add_sum;
      cnt           <= cnt_next;
      ovf           <= row_ovf;
      bus.out_valid <= 1'b0;
      state         <= S_ACCUM;
    end else if ((state == S_HOLD) && bus.out_ready) begin
      // Result drained with no new element this cycle.
      bus.out_valid <= 1'b0;
      state         <= S_ACCUM;
    end
  end

  // A held result must not change or vanish while downstream stalls.
  property p_hold_stable;
    @(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_sum) && $stable(bus.out_count) &&
         $stable(bus.out_ovf));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

  // No element may enter while a result is stalled.
  property p_no_accept_in_stall;
    @(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |-> !bus.in_ready;
  endproperty
  a_no_accept_in_stall: assert property (p_no_accept_in_stall);

endmodule

// File: tb/tb_row_accumulator.sv
// Bench for row_accumulator: reset checks, a table of hand-computed rows, random
// rows scored against a wide-arithmetic model, and hand sequences for stall,
// drain-and-refill, reset mid-row / mid-HOLD and counter saturation.
module tb_row_accumulator;
  import row_acc_pkg::*;

  localparam int EW = 64;
  localparam int CW = 8;
  localparam int SW = 1 + CW + EW;

  localparam logic [EW-1:0] MP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [EW-1:0] MN = 64'h8000_0000_0000_0000;

  typedef struct {
    int            n;
    logic [EW-1:0] d [6];
    logic [EW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  row_accumulator_if #(.ELEMENT_WIDTH(EW), .COUNT_WIDTH(CW)) bus ();
  row_accumulator_if #(.ELEMENT_WIDTH(EW), .COUNT_WIDTH(2))  bus2 ();
  state_e dbg_state;
  state_e dbg_state2;

  row_accumulator #(.ELEMENT_WIDTH(EW), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  row_accumulator #(.ELEMENT_WIDTH(EW), .COUNT_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .dbg_state (dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] mon_exp;
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result transfers happen at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {bus.out_ovf, bus.out_count, bus.out_sum});
      end else begin
        mon_exp = exp_q.pop_front();
        check("row_result", {bus.out_ovf, bus.out_count, bus.out_sum}, mon_exp);
      end
    end
  end

  // ---------------- reference model ----------------
  // One add computed one bit wider so overflow is a range check, not a sign rule.
  task automatic model_add(input logic [EW-1:0] a, input logic [EW-1:0] b,
                           output logic [EW-1:0] s, output logic o);
    logic signed [EW:0] wide;
    wide = $signed({a[EW-1], a}) + $signed({b[EW-1], b});
    o = (wide[EW] != wide[EW-1]);
`ifdef ROW_ACC_SATURATE_EN
    s = o ? (wide[EW] ? MN : MP) : wide[EW-1:0];
`else
    s = wide[EW-1:0];
`endif
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_elem(input logic [EW-1:0] d, input logic last);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!got && k < 64) begin
      @(negedge clk);
      got = bus.in_ready;
      tick();
      k++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 64 cycles");
    end
    // Garbage on the idle bus must be ignored.
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_row(input int n, input logic [EW-1:0] d [6], input logic [SW-1:0] expv);
    exp_q.push_back(expv);
    for (int i = 0; i < n; i++) begin
      drive_elem(d[i], (i == n - 1));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("drain_empty", SW'(exp_q.size()), SW'(0));
  endtask

  // ---------------- test ----------------
  vec_t          vt [8];
  logic [EW-1:0] rd [6];
  logic [EW-1:0] ms;
  logic          mo;
  logic          o1;
  int            rn;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b1;

    vt[0] = '{n: 4, d: '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd0},
              sum: 64'd10, cnt: 8'd4, ovf: 1'b0};
    vt[1] = '{n: 1, d: '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
              sum: 64'hFFFF_FFFF_FFFF_FFFB, cnt: 8'd1, ovf: 1'b0};
    vt[4] = '{n: 3, d: '{64'd100, 64'hFFFF_FFFF_FFFF_FED4, 64'd50, 64'd0, 64'd0, 64'd0},
              sum: 64'hFFFF_FFFF_FFFF_FF6A, cnt: 8'd3, ovf: 1'b0};
    vt[5] = '{n: 1, d: '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0},
              sum: 64'd0, cnt: 8'd1, ovf: 1'b0};
    vt[7] = '{n: 6, d: '{'1, '1, '1, '1, '1, '1},
              sum: 64'hFFFF_FFFF_FFFF_FFFA, cnt: 8'd6, ovf: 1'b0};
`ifdef ROW_ACC_SATURATE_EN
    vt[2] = '{n: 2, d: '{MP, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0}, sum: MP, cnt: 8'd2, ovf: 1'b1};
    vt[3] = '{n: 2, d: '{MN, '1, 64'd0, 64'd0, 64'd0, 64'd0}, sum: MN, cnt: 8'd2, ovf: 1'b1};
    vt[6] = '{n: 3, d: '{MP, 64'd1, '1, 64'd0, 64'd0, 64'd0},
              sum: 64'h7FFF_FFFF_FFFF_FFFE, cnt: 8'd3, ovf: 1'b1};
`else
    vt[2] = '{n: 2, d: '{MP, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0}, sum: MN, cnt: 8'd2, ovf: 1'b1};
    vt[3] = '{n: 2, d: '{MN, '1, 64'd0, 64'd0, 64'd0, 64'd0}, sum: MP, cnt: 8'd2, ovf: 1'b1};
    vt[6] = '{n: 3, d: '{MP, 64'd1, '1, 64'd0, 64'd0, 64'd0}, sum: MP, cnt: 8'd3, ovf: 1'b1};
`endif

    // Reset values.
    #12;
    check("reset_out_valid", SW'(bus.out_valid), SW'(0));
    check("reset_out_sum",   SW'(bus.out_sum),   SW'(0));
    check("reset_out_count", SW'(bus.out_count), SW'(0));
    check("reset_out_ovf",   SW'(bus.out_ovf),   SW'(0));
    check("reset_in_ready",  SW'(bus.in_ready),  SW'(1));
    check("reset_state",     SW'(dbg_state),     SW'(ACCUM));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency: result visible one cycle after the last accept.
    exp_q.push_back({1'b0, 8'd4, 64'd10});
    for (int i = 0; i < 4; i++) drive_elem(64'(i + 1), (i == 3));
    check("lat_valid", SW'(bus.out_valid), SW'(1));
    check("lat_sum",   SW'(bus.out_sum),   SW'(10));
    check("lat_count", SW'(bus.out_count), SW'(4));
    tick();

    // Table rows under random backpressure.
    bp_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      send_row(vt[v].n, vt[v].d, {vt[v].ovf, vt[v].cnt, vt[v].sum});
    end

    // Random rows scored by the model.
    for (int r = 0; r < 10; r++) begin
      rn = $urandom_range(1, 6);
      ms = '0;
      mo = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 1) == 1) rd[i] = {$urandom, $urandom};
        else rd[i] = 64'($signed($urandom_range(0, 2000)) - 1000);
        if (i < rn) begin
          model_add(ms, rd[i], ms, o1);
          mo = mo | o1;
        end
      end
      send_row(rn, rd, {mo, CW'(rn), ms});
    end
    drain();

    // Stall: result held five cycles, upstream waiting with a one-element row.
    bus.out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'd1, 64'd9});
    drive_elem(64'd9, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'd7;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready",  SW'(bus.in_ready),  SW'(0));
      check("stall_out_valid", SW'(bus.out_valid), SW'(1));
      check("stall_out_sum",   SW'(bus.out_sum),   SW'(9));
      check("stall_out_count", SW'(bus.out_count), SW'(1));
      check("stall_state",     SW'(dbg_state),     SW'(HOLD));
      tick();
    end
    exp_q.push_back({1'b0, 8'd1, 64'd7});
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("refill_in_ready", SW'(bus.in_ready), SW'(1));
    tick();
    bus.in_valid = 1'b0;
    check("refill_valid", SW'(bus.out_valid), SW'(1));
    check("refill_sum",   SW'(bus.out_sum),   SW'(7));
    check("refill_count", SW'(bus.out_count), SW'(1));
    drain();

    // Reset after two elements of a row.
    drive_elem(64'd5, 1'b0);
    drive_elem(64'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_row_out_valid", SW'(bus.out_valid), SW'(0));
    check("rst_row_out_sum",   SW'(bus.out_sum),   SW'(0));
    check("rst_row_out_count", SW'(bus.out_count), SW'(0));
    check("rst_row_out_ovf",   SW'(bus.out_ovf),   SW'(0));
    check("rst_row_in_ready",  SW'(bus.in_ready),  SW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 8'd2, 64'd4});
    drive_elem(64'd2, 1'b0);
    drive_elem(64'd2, 1'b1);
    check("after_rst_sum",   SW'(bus.out_sum),   SW'(4));
    check("after_rst_count", SW'(bus.out_count), SW'(2));
    drain();

    // Reset while a result is held: the pending result is discarded.
    bus.out_ready = 1'b0;
    drive_elem(64'd3, 1'b1);
    check("hold_before_rst", SW'(bus.out_valid), SW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_out_valid", SW'(bus.out_valid), SW'(0));
    check("rst_hold_state",     SW'(dbg_state),     SW'(ACCUM));
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Counter saturation on the narrow-count instance: five ones.
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 64'd1;
      bus2.in_last  = (i == 4);
      @(negedge clk);
      check("sat_in_ready", SW'(bus2.in_ready), SW'(1));
      tick();
    end
    bus2.in_valid = 1'b0;
    check("sat_valid", SW'(bus2.out_valid), SW'(1));
    check("sat_count", SW'(bus2.out_count), SW'(3));
    check("sat_sum",   SW'(bus2.out_sum),   SW'(5));
    check("sat_ovf",   SW'(bus2.out_ovf),   SW'(0));
    tick();

    // Final report.
    check("queue_empty", SW'(exp_q.size()), SW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_accumulator.md
Name: row_accumulator

Overview:
- Consumes the aligned 64-bit element stream produced by the 4-stage delay line and reduces each row to a single signed sum.
- A row is the sequence of elements up to and including one flagged last.
- The sum and the row's element count are delivered on a valid/ready output port.
- Sits directly downstream of the delay stage and feeds the result/writeback logic.

Parameters:
- ELEMENT_WIDTH, 64, width of input elements and of the sum (signed two's complement).
- COUNT_WIDTH, 8, width of the per-row element counter.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  element present on in_data
- in_ready  output  1  block accepts an element this cycle
- in_data  input  ELEMENT_WIDTH  signed element
- in_last  input  1  element closes the current row
- out_valid  output  1  result pending
- out_ready  input  1  downstream accepts the result
- out_sum  output  ELEMENT_WIDTH  signed row sum
- out_count  output  COUNT_WIDTH  number of elements in the row
- out_ovf  output  1  signed overflow occurred in this row

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, asynchronous):
  - state=ACCUM; acc=0; cnt=0; ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready follows its combinational definition, so it reads 1 in ACCUM.
- Accept: an input element is accepted when in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- in_ready = (state==ACCUM) | (state==HOLD & out_ready). A new row can start in the same cycle the previous result drains.
- States: ACCUM (summing), HOLD (result registered, waiting for out_ready).
- ACCUM, accept without in_last:
  - acc <= acc + in_data; cnt <= cnt+1.
  - ovf <= ovf | signed-overflow of that add.
- ACCUM, accept with in_last:
  - out_sum <= acc + in_data; out_count <= cnt+1; out_ovf <= ovf | overflow.
  - out_valid <= 1; acc, cnt, ovf <= 0; state <= HOLD.
- Latency: result is visible one cycle after the last element is accepted.
- A single-element row (in_last on the first element) gives out_sum=in_data, out_count=1.
- HOLD, out_ready=0: all outputs are stable; in_ready=0 (no data loss; upstream must hold).
- HOLD, out_ready=1, no accept: out_valid <= 0; state <= ACCUM.
- HOLD, out_ready=1 with accept: the accepted element starts a new row, with acc seeded from in_data instead of zero.
  - With in_last: the new result is loaded, out_valid stays 1, state stays HOLD.
  - Without in_last: acc <= in_data, cnt <= 1, state <= ACCUM.
- Count boundary: cnt saturates at 2^COUNT_WIDTH-1; further elements still add to the sum.
- Sum arithmetic: ELEMENT_WIDTH-bit signed. Overflow is detected as operands of equal sign giving a result of the opposite sign.
- Reset mid-row or mid-HOLD discards the partial sum and any pending result.
- in_data and in_last are ignored when not accepted.

Optional Feature:
- Macro ROW_ACC_SATURATE_EN.
- Defined: each add clamps to the most positive / most negative representable value on overflow, and out_ovf is set.
- Undefined: the add wraps modulo 2^ELEMENT_WIDTH; out_ovf still reports that overflow occurred.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package row_acc_pkg holds:
  - state enum {ACCUM, HOLD};
  - default ELEMENT_WIDTH/COUNT_WIDTH constants;
  - MAX_POS/MAX_NEG constant functions of width.
- One sub-module, acc_adder: combinational signed add with overflow flag and saturation under the macro. It is instantiated once and shared by the normal and seeded paths.

Test Plan:
- Row 1,2,3,4 (last on 4), out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=10, out_count=4, out_ovf=0.
- Single element -5 with in_last -> out_sum=-5 (0xFFFF_FFFF_FFFF_FFFB), out_count=1.
- Row 0x7FFF_FFFF_FFFF_FFFF, 1 (last):
  - Macro defined -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
  - Macro undefined -> out_sum=0x8000_0000_0000_0000, out_ovf=1.
- out_ready held 0 for 5 cycles after a result -> in_ready=0 and outputs stable throughout; raising out_ready together with in_valid, data 7, last -> next cycle out_sum=7, out_count=1, out_valid=1.
- rst_n pulsed low after 2 elements of a row -> all outputs 0 immediately; the next row 2,2 (last) gives out_sum=4, out_count=2.
- COUNT_WIDTH=2, row of 5 ones -> out_count=3 (saturated), out_sum=5.
